// File: rtl/goertzel_bin_power.sv
// Captures a frame of BIN_NUM complex bins, squares each with one shared multiplier, streams power per bin.
// Bin k power is valid 2(k+1) cycles after the last accept; o_ready is low during the 2*BIN_NUM compute cycles and samples offered then are dropped.
module goertzel_bin_power #(
  parameter int WIDTH   = 12,
  parameter int BIN_NUM = 4
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst,
  input  logic                       i_valid,
  input  logic signed [WIDTH-1:0]    i_re,
  input  logic signed [WIDTH-1:0]    i_im,
  output logic                       o_ready,
  output logic [2*WIDTH-1:0]         o_pow,
  output logic [$clog2(BIN_NUM)-1:0] o_pow_bin,
  output logic                       o_pow_valid,
  output logic [$clog2(BIN_NUM)-1:0] o_peak_bin,
  output logic [2*WIDTH-1:0]         o_peak_pow,
  output logic                       o_frame_done,
  output logic                       o_overrun
);

  localparam int BW = $clog2(BIN_NUM);
  localparam int PW = 2 * WIDTH;
  localparam logic [BW-1:0] LAST = BW'(BIN_NUM - 1);

  typedef enum logic [1:0] {CAPTURE, SQ_RE, SQ_IM} state_e;

  state_e state_q, state_d;

  logic [BW-1:0]           cnt_q, k_q;
  logic signed [WIDTH-1:0] buf_re [BIN_NUM];
  logic signed [WIDTH-1:0] buf_im [BIN_NUM];
  logic [PW-1:0]           acc_q;
  logic [PW-1:0]           pow_q;
  logic [BW-1:0]           pow_bin_q;
  logic                    pow_valid_q;
  logic                    frame_done_q;
  logic [BW-1:0]           cand_bin_q, peak_bin_q;
  logic [PW-1:0]           cand_pow_q, peak_pow_q;
  logic                    overrun_q;

  logic                    accept;
  logic signed [WIDTH-1:0] sq_op;
  logic signed [PW-1:0]    sq_ext;
  logic [PW-1:0]           sq;
  logic [PW-1:0]           p;
  logic                    better;
  logic [BW-1:0]           cand_bin_n;
  logic [PW-1:0]           cand_pow_n;

  assign accept = (state_q == CAPTURE) && i_valid;

  // Single multiplier: real part squared in SQ_RE, imaginary part in SQ_IM.
  assign sq_op  = (state_q == SQ_IM) ? buf_im[k_q] : buf_re[k_q];
  assign sq_ext = PW'(sq_op);
  assign sq     = sq_ext * sq_ext;
  assign p      = acc_q + sq;

  // Strict compare keeps the lowest bin index on ties; bin 0 always seeds the candidate.
  assign better     = (k_q == '0) || (p > cand_pow_q);
  assign cand_bin_n = better ? k_q : cand_bin_q;
  assign cand_pow_n = better ? p : cand_pow_q;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (accept && (cnt_q == LAST)) state_d = SQ_RE;
      SQ_RE:   state_d = SQ_IM;
      SQ_IM:   state_d = (k_q == LAST) ? CAPTURE : SQ_RE;
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (accept) begin
      buf_re[cnt_q] <= i_re;
      buf_im[cnt_q] <= i_im;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cnt_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      pow_q        <= '0;
      pow_bin_q    <= '0;
      pow_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cand_bin_q   <= '0;
      cand_pow_q   <= '0;
      peak_bin_q   <= '0;
      peak_pow_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      pow_valid_q  <= (state_q == SQ_IM);
      frame_done_q <= (state_q == SQ_IM) && (k_q == LAST);
      if (accept) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + BW'(1);
      end
      if (i_valid && (state_q != CAPTURE)) begin
        overrun_q <= 1'b1;
      end
      if (state_q == SQ_RE) begin
        acc_q <= sq;
      end
      if (state_q == SQ_IM) begin
        pow_q      <= p;
        pow_bin_q  <= k_q;
        cand_bin_q <= cand_bin_n;
        cand_pow_q <= cand_pow_n;
        k_q        <= (k_q == LAST) ? '0 : k_q + BW'(1);
        if (k_q == LAST) begin
          peak_bin_q <= cand_bin_n;
          peak_pow_q <= cand_pow_n;
        end
      end
    end
  end

  assign o_ready      = (state_q == CAPTURE);
  assign o_pow        = pow_q;
  assign o_pow_bin    = pow_bin_q;
  assign o_pow_valid  = pow_valid_q;
  assign o_peak_bin   = peak_bin_q;
  assign o_peak_pow   = peak_pow_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule
